clockgen_lock_supervisor: RTL and testbench

Supervises the 50 MHz-referenced MMCM clock generator from the other side of its reset/locked handshake. It drives the generator's reset input, watches its `locked` output, retries when lock is not achieved in time, and flags repeated failures. It releases a clean system reset only after lock has been stable for a settle interval. It runs on the free-running board clock, so it keeps working while the generated dot4x/col4x clocks are absent.

---
 rtl/clockgen_lock_supervisor.sv | 168 ++++++++++++++++
 tb/tb_clockgen_lock_supervisor.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clockgen_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : clockgen_lock_supervisor
// Brief    : Drives the MMCM reset/locked handshake from the board clock,
//            retries on lock timeout and releases a settled system reset.
// Revision : 1.0 - initial release
// ============================================================================
module clockgen_lock_supervisor #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 5000,
    parameter int SETTLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 7
) (
    input  logic       clk_in50mhz,
    input  logic       reset,
    input  logic       locked,
    output logic       mmcm_reset,
    output logic       sys_reset,
    output logic       lock_fault,
    output logic [7:0] relock_count
);

    localparam int c_MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int c_CNT_MAX = (c_MAX_A > SETTLE_CYCLES) ? c_MAX_A : SETTLE_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_RTY_W   = $clog2(MAX_RETRIES + 1);

    localparam logic [c_CNT_W-1:0] c_RST_TC    = c_CNT_W'(RST_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_TC = c_CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_SETTLE_TC = c_CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_TOP   = c_CNT_W'(c_CNT_MAX);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_RTY_W-1:0] c_RTY_MAX   = c_RTY_W'(MAX_RETRIES);
    localparam logic [c_RTY_W-1:0] c_RTY_ONE   = c_RTY_W'(1);

    typedef enum logic [1:0] {
        S_RESET     = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_SETTLE    = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic [c_RTY_W-1:0]   r_retry_cnt;
    logic [c_RTY_W-1:0]   w_retry_nxt;
    logic [1:0]           r_sync;
    logic                 w_locked_s;
    logic                 r_mmcm_reset;
    logic                 w_mmcm_reset_nxt;
    logic                 r_sys_reset;
    logic                 w_sys_reset_nxt;
    logic                 r_lock_fault;
    logic                 w_lock_fault_nxt;
    logic [7:0]           r_relock_count;
    logic [7:0]           w_relock_nxt;

    // locked comes from the MMCM domain; only the synchronized copy is used.
    always_ff @(posedge clk_in50mhz or posedge reset) begin
        if (reset) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], locked};
        end
    end

    assign w_locked_s = r_sync[1];

    always_ff @(posedge clk_in50mhz or posedge reset) begin
        if (reset) begin
            r_state        <= S_RESET;
            r_cnt          <= '0;
            r_retry_cnt    <= '0;
            r_mmcm_reset   <= 1'b1;
            r_sys_reset    <= 1'b1;
            r_lock_fault   <= 1'b0;
            r_relock_count <= 8'd0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_retry_cnt    <= w_retry_nxt;
            r_mmcm_reset   <= w_mmcm_reset_nxt;
            r_sys_reset    <= w_sys_reset_nxt;
            r_lock_fault   <= w_lock_fault_nxt;
            r_relock_count <= w_relock_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_retry_nxt      = r_retry_cnt;
        w_mmcm_reset_nxt = r_mmcm_reset;
        w_sys_reset_nxt  = r_sys_reset;
        w_lock_fault_nxt = r_lock_fault;
        w_relock_nxt     = r_relock_count;

        case (r_state)
            S_RESET: begin
                w_mmcm_reset_nxt = 1'b1;
                w_sys_reset_nxt  = 1'b1;
                if (r_cnt == c_RST_TC) begin
                    w_state_nxt      = S_WAIT_LOCK;
                    w_mmcm_reset_nxt = 1'b0;
                end
            end
            S_WAIT_LOCK: begin
                if (w_locked_s) begin
                    w_state_nxt = S_SETTLE;
                end else if (r_cnt == c_TIMEOUT_TC) begin
                    w_state_nxt      = S_RESET;
                    w_mmcm_reset_nxt = 1'b1;
                    if (r_retry_cnt != c_RTY_MAX) begin
                        w_retry_nxt = r_retry_cnt + c_RTY_ONE;
                    end
                    // Fault flags on the same edge the retry count hits the limit.
                    if (int'(r_retry_cnt) >= MAX_RETRIES - 1) begin
                        w_lock_fault_nxt = 1'b1;
                    end
                end
            end
            S_SETTLE: begin
                if (!w_locked_s) begin
                    w_state_nxt      = S_RESET;
                    w_mmcm_reset_nxt = 1'b1;
                end else if (r_cnt == c_SETTLE_TC) begin
                    w_state_nxt     = S_RUN;
                    w_sys_reset_nxt = 1'b0;
                    w_retry_nxt     = '0;
                end
            end
            S_RUN: begin
                if (!w_locked_s) begin
                    w_state_nxt      = S_RESET;
                    w_mmcm_reset_nxt = 1'b1;
                    w_sys_reset_nxt  = 1'b1;
                    if (r_relock_count != 8'hFF) begin
                        w_relock_nxt = r_relock_count + 8'd1;
                    end
                end
            end
            default: begin
                w_state_nxt      = S_RESET;
                w_mmcm_reset_nxt = 1'b1;
                w_sys_reset_nxt  = 1'b1;
            end
        endcase
    end

    // Shared counter restarts on every state change and parks at its top value.
    always_comb begin
        if (w_state_nxt != r_state) begin
            w_cnt_nxt = '0;
        end else if (r_cnt == c_CNT_TOP) begin
            w_cnt_nxt = r_cnt;
        end else begin
            w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
    end

    assign mmcm_reset   = r_mmcm_reset;
    assign sys_reset    = r_sys_reset;
    assign lock_fault   = r_lock_fault;
    assign relock_count = r_relock_count;

endmodule
`default_nettype wire

// File: tb/tb_clockgen_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : tb_clockgen_lock_supervisor
// Brief    : Scoreboard bench for clockgen_lock_supervisor (edge-indexed).
// Revision : 1.0 - initial release
// ============================================================================
module tb_clockgen_lock_supervisor;

    logic       clk;
    logic       reset;
    logic       locked;
    logic       mmcm_reset;
    logic       sys_reset;
    logic       lock_fault;
    logic [7:0] relock_count;

    int errors = 0;
    int checks = 0;
    int edge_cnt;

    typedef struct {
        int          e;
        logic [10:0] v;
        string       name;
    } exp_t;

    exp_t q[$];

    clockgen_lock_supervisor #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (20),
        .SETTLE_CYCLES (8),
        .MAX_RETRIES   (2)
    ) dut (
        .clk_in50mhz  (clk),
        .reset        (reset),
        .locked       (locked),
        .mmcm_reset   (mmcm_reset),
        .sys_reset    (sys_reset),
        .lock_fault   (lock_fault),
        .relock_count (relock_count)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Edge 1 is the first rising edge after reset deasserts.
    always @(posedge clk or posedge reset) begin
        if (reset) edge_cnt <= 0;
        else       edge_cnt <= edge_cnt + 1;
    end

    function automatic void push(int e, logic m, logic s, logic f, logic [7:0] c, string name);
        exp_t x;
        x.e = e;
        x.v = {m, s, f, c};
        x.name = name;
        q.push_back(x);
    endfunction

    task automatic start();
        @(negedge clk);
        reset  = 1'b1;
        locked = 1'b0;
        q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset  = 1'b1;
        locked = 1'b1;
        #3;
        checks++;
        if ({mmcm_reset, sys_reset, lock_fault, relock_count} !== {1'b1, 1'b1, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL reset_values: got mmcm=%b sys=%b fault=%b cnt=%0d, want 1 1 0 0",
                     mmcm_reset, sys_reset, lock_fault, relock_count);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_nominal();
        start();
        push(3, 1, 1, 0, 0, "nom_e3");
        push(4, 0, 1, 0, 0, "nom_mmcm_fall_e4");
        push(12, 0, 1, 0, 0, "nom_e12");
        push(19, 0, 1, 0, 0, "nom_e19");
        push(20, 0, 0, 0, 0, "nom_sys_fall_e20");
        push(22, 0, 0, 0, 0, "nom_e22");
        while (edge_cnt < 22) begin
            @(negedge clk);
            if (edge_cnt == 9) locked = 1'b1;
            while (q.size() > 0 && q[0].e <= edge_cnt) begin
                exp_t x;
                x = q.pop_front();
                checks++;
                if ({mmcm_reset, sys_reset, lock_fault, relock_count} !== x.v) begin
                    errors++;
                    $display("FAIL %s: edge %0d got %b want %b", x.name, edge_cnt,
                             {mmcm_reset, sys_reset, lock_fault, relock_count}, x.v);
                end
            end
        end
    endtask

    task automatic test_timeout_fault();
        start();
        push(23, 0, 1, 0, 0, "to_e23");
        push(24, 1, 1, 0, 0, "to_rise_e24");
        push(27, 1, 1, 0, 0, "to_e27");
        push(28, 0, 1, 0, 0, "to_fall_e28");
        push(47, 0, 1, 0, 0, "to_e47");
        push(48, 1, 1, 1, 0, "to_fault_e48");
        push(52, 0, 1, 1, 0, "to_retry_fall_e52");
        push(72, 1, 1, 1, 0, "to_retry_rise_e72");
        while (edge_cnt < 72) begin
            @(negedge clk);
            while (q.size() > 0 && q[0].e <= edge_cnt) begin
                exp_t x;
                x = q.pop_front();
                checks++;
                if ({mmcm_reset, sys_reset, lock_fault, relock_count} !== x.v) begin
                    errors++;
                    $display("FAIL %s: edge %0d got %b want %b", x.name, edge_cnt,
                             {mmcm_reset, sys_reset, lock_fault, relock_count}, x.v);
                end
            end
        end
    endtask

    task automatic test_settle_glitch();
        start();
        push(15, 0, 1, 0, 0, "gl_e15");
        push(16, 1, 1, 0, 0, "gl_rise_e16");
        push(19, 1, 1, 0, 0, "gl_e19");
        push(20, 0, 1, 0, 0, "gl_fall_e20");
        push(28, 0, 1, 0, 0, "gl_e28");
        push(29, 0, 0, 0, 0, "gl_run_e29");
        while (edge_cnt < 29) begin
            @(negedge clk);
            if (edge_cnt == 9)  locked = 1'b1;
            if (edge_cnt == 13) locked = 1'b0;
            if (edge_cnt == 14) locked = 1'b1;
            while (q.size() > 0 && q[0].e <= edge_cnt) begin
                exp_t x;
                x = q.pop_front();
                checks++;
                if ({mmcm_reset, sys_reset, lock_fault, relock_count} !== x.v) begin
                    errors++;
                    $display("FAIL %s: edge %0d got %b want %b", x.name, edge_cnt,
                             {mmcm_reset, sys_reset, lock_fault, relock_count}, x.v);
                end
            end
        end
    endtask

    task automatic test_loss_in_run();
        start();
        push(20, 0, 0, 0, 0, "loss_run_e20");
        push(41, 0, 0, 0, 0, "loss_e41");
        push(42, 1, 1, 0, 1, "loss_e42");
        push(45, 1, 1, 0, 1, "loss_e45");
        push(46, 0, 1, 0, 1, "loss_fall_e46");
        push(54, 0, 1, 0, 1, "loss_e54");
        push(55, 0, 0, 0, 1, "loss_rerun_e55");
        while (edge_cnt < 55) begin
            @(negedge clk);
            if (edge_cnt == 9)  locked = 1'b1;
            if (edge_cnt == 39) locked = 1'b0;
            if (edge_cnt == 43) locked = 1'b1;
            while (q.size() > 0 && q[0].e <= edge_cnt) begin
                exp_t x;
                x = q.pop_front();
                checks++;
                if ({mmcm_reset, sys_reset, lock_fault, relock_count} !== x.v) begin
                    errors++;
                    $display("FAIL %s: edge %0d got %b want %b", x.name, edge_cnt,
                             {mmcm_reset, sys_reset, lock_fault, relock_count}, x.v);
                end
            end
        end
    endtask

    task automatic test_saturation_async_reset();
        int e;
        int n;
        start();
        push(20, 0, 0, 0, 0, "sat_run_e20");
        while (edge_cnt < 20) begin
            @(negedge clk);
            if (edge_cnt == 9) locked = 1'b1;
            while (q.size() > 0 && q[0].e <= edge_cnt) begin
                exp_t x;
                x = q.pop_front();
                checks++;
                if ({mmcm_reset, sys_reset, lock_fault, relock_count} !== x.v) begin
                    errors++;
                    $display("FAIL %s: edge %0d got %b want %b", x.name, edge_cnt,
                             {mmcm_reset, sys_reset, lock_fault, relock_count}, x.v);
                end
            end
        end
        for (int i = 1; i <= 300; i++) begin
            // Drop before edge e+1: loss seen at e+3, relock reaches RUN at e+16.
            e = edge_cnt;
            n = (i > 255) ? 255 : i;
            locked = 1'b0;
            push(e + 3, 1, 1, 0, 8'(n), "sat_loss");
            push(e + 16, 0, 0, 0, 8'(n), "sat_run");
            while (edge_cnt < e + 16) begin
                @(negedge clk);
                if (edge_cnt == e + 3) locked = 1'b1;
                while (q.size() > 0 && q[0].e <= edge_cnt) begin
                    exp_t x;
                    x = q.pop_front();
                    checks++;
                    if ({mmcm_reset, sys_reset, lock_fault, relock_count} !== x.v) begin
                        errors++;
                        $display("FAIL %s#%0d: edge %0d got %b want %b", x.name, i, edge_cnt,
                                 {mmcm_reset, sys_reset, lock_fault, relock_count}, x.v);
                    end
                end
            end
        end
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({mmcm_reset, sys_reset, lock_fault, relock_count} !== {1'b1, 1'b1, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL async_reset: got mmcm=%b sys=%b fault=%b cnt=%0d, want 1 1 0 0",
                     mmcm_reset, sys_reset, lock_fault, relock_count);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checks++;
        if (q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", q.size());
        end
    endtask

    initial begin
        reset  = 1'b1;
        locked = 1'b0;
        test_reset();
        test_nominal();
        test_timeout_fault();
        test_settle_glitch();
        test_loss_in_run();
        test_saturation_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
